// File: rtl/ro_freq_ctrl_pkg.sv
// Shared definitions for the ring-oscillator frequency controller.
//  ro_state_e     : FSM encodings (IDLE=0, SETTLE=1, GATE=2, DONE=3)
//  RO_SYNC_DEPTH  : flops in the ro_in clock-domain synchronizer
//  max2()         : elaboration-time max, used to size the shared timer
`timescale 1ns/100ps
package ro_freq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2,
    DONE   = 2'd3
  } ro_state_e;

  localparam int RO_SYNC_DEPTH = 2;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ro_sync_edge.sv
// Synchronizer + rising-edge detector for the asynchronous ring tap.
//  clk        in  system clock
//  rst_n      in  async active-low reset
//  async_in   in  ring oscillator tap (asynchronous to clk)
//  rise_pulse out one-clk pulse per synced rising edge (3 clk after the edge)
// The chain is never cleared by FSM state so edges straddling window
// boundaries are attributed by detection time.
`timescale 1ns/100ps
module ro_sync_edge
  import ro_freq_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic [RO_SYNC_DEPTH-1:0] sync;
  logic                     prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[RO_SYNC_DEPTH-2:0], async_in};
      prev <= sync[RO_SYNC_DEPTH-1];
    end
  end

  assign rise_pulse = sync[RO_SYNC_DEPTH-1] & ~prev;

endmodule

// File: rtl/ro_freq_ctrl.sv
// Ring oscillator sequencer and frequency counter.
// Enables the ring, lets it settle, counts synced rising edges over a
// fixed gate window, parks the ring and holds the result until acked.
//  clk, rst_n      clock / async active-low reset
//  start           request a measurement (honoured in IDLE only)
//  ro_in           ring tap (async)
//  ro_en           ring enable, high in SETTLE and GATE
//  busy            high in SETTLE, GATE, DONE
//  cnt_valid       result valid, held until cnt_ack
//  cnt_data        edge count of last window
//  cnt_ack         consumer accepts result (honoured in DONE only)
//  ovf             count exceeded 2**CNT_W-1 in last window
// Build option RO_SAT_EN: saturate the count instead of wrapping.
`timescale 1ns/100ps
module ro_freq_ctrl
  import ro_freq_ctrl_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int GATE_CYCLES   = 1000,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ro_in,
  output logic             ro_en,
  output logic             busy,
  output logic             cnt_valid,
  output logic [CNT_W-1:0] cnt_data,
  input  logic             cnt_ack,
  output logic             ovf
);

  localparam int TW = $clog2(max2(GATE_CYCLES, SETTLE_CYCLES) + 1);

  ro_state_e     state, state_n;
  logic [TW-1:0] timer, timer_n;
  // MSB is a sticky overflow flag; low CNT_W bits are the edge count.
  logic [CNT_W:0] cnt, cnt_n, cnt_inc;
  logic           pulse;

  ro_sync_edge u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (ro_in),
    .rise_pulse (pulse)
  );

  always_comb begin
    state_n = state;
    timer_n = timer;
    case (state)
      IDLE: if (start) begin
        state_n = SETTLE;
        timer_n = TW'(SETTLE_CYCLES - 1);
      end
      SETTLE: if (timer == '0) begin
        state_n = GATE;
        timer_n = TW'(GATE_CYCLES - 1);
      end else begin
        timer_n = timer - 1'b1;
      end
      GATE: if (timer == '0) state_n = DONE;
            else             timer_n = timer - 1'b1;
      DONE: if (cnt_ack) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next count includes a pulse on the final GATE cycle, so the value
  // latched into cnt_data covers exactly GATE_CYCLES detection slots.
  always_comb begin
    cnt_inc = {1'b0, cnt[CNT_W-1:0]} + {{CNT_W{1'b0}}, 1'b1};
    cnt_n   = cnt;
    if (state == SETTLE) begin
      cnt_n = '0;
    end else if (state == GATE && pulse) begin
`ifdef RO_SAT_EN
      if (&cnt[CNT_W-1:0]) cnt_n = {1'b1, cnt[CNT_W-1:0]};
      else                 cnt_n = {cnt[CNT_W], cnt_inc[CNT_W-1:0]};
`else
      cnt_n = {cnt[CNT_W] | cnt_inc[CNT_W], cnt_inc[CNT_W-1:0]};
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      cnt       <= '0;
      ro_en     <= 1'b0;
      busy      <= 1'b0;
      cnt_valid <= 1'b0;
      cnt_data  <= '0;
      ovf       <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      cnt       <= cnt_n;
      ro_en     <= (state_n == SETTLE) || (state_n == GATE);
      busy      <= (state_n != IDLE);
      cnt_valid <= (state_n == DONE);
      if (state == GATE && state_n == DONE) begin
        cnt_data <= cnt_n[CNT_W-1:0];
        ovf      <= cnt_n[CNT_W];
      end
    end
  end

endmodule

// File: tb/tb_ro_freq_ctrl.sv
// Scoreboard bench for ro_freq_ctrl (CNT_W=4, GATE=100, SETTLE=16).
// Stimulus pushes the expected result window; a negedge monitor pops and
// compares on each rising cnt_valid.
`timescale 1ns/100ps
module tb_ro_freq_ctrl;

  localparam int CW = 4;
  localparam int GC = 100;
  localparam int SC = 16;
  localparam int LAT = SC + GC + 1;

  typedef struct {
    int lo;
    int hi;
    bit ov;
  } exp_t;

  logic          clk = 0, rst_n = 0, start = 0, cnt_ack = 0, ro_in;
  logic          ro_en, busy, cnt_valid, ovf;
  logic [CW-1:0] cnt_data;

  exp_t q[$];
  int   checks = 0, errors = 0, nres = 0;
  int   rmode = 0;   // 0 tie low, 1 tie high, 2 toggle while ro_en
  int   rhalf = 5;   // ring half-period in clk cycles

  ro_freq_ctrl #(.CNT_W(CW), .GATE_CYCLES(GC), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ro_in(ro_in), .ro_en(ro_en),
    .busy(busy), .cnt_valid(cnt_valid), .cnt_data(cnt_data),
    .cnt_ack(cnt_ack), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Ring model, phase-shifted off the clock grid.
  initial begin
    ro_in = 1'b0;
    #0.3;
    forever begin
      if (rmode == 2 && ro_en) begin
        #(rhalf * 10);
        if (rmode == 2) ro_in = ~ro_in;
      end else begin
        if (rmode == 0) ro_in = 1'b0;
        else if (rmode == 1) ro_in = 1'b1;
        #1;
      end
    end
  end

  task automatic chk(input bit ok, input string nm, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Monitor
  initial begin
    bit   vprev = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && cnt_valid && !vprev) begin
        nres++;
        if (q.size() == 0) begin
          chk(0, "unexpected_result", int'(cnt_data), -1);
        end else begin
          e = q.pop_front();
          chk(int'(cnt_data) >= e.lo && int'(cnt_data) <= e.hi, "cnt_data", int'(cnt_data), e.lo);
          chk(ovf == e.ov, "ovf", int'(ovf), int'(e.ov));
          chk(ro_en == 1'b0, "ro_en_in_done", int'(ro_en), 0);
          chk(busy == 1'b1, "busy_in_done", int'(busy), 1);
        end
      end
      vprev = cnt_valid;
    end
  end

  // One measurement; returns at edge+1 where cnt_valid first seen.
  task automatic run_meas(input int lo, input int hi, input bit ov, input bit lat_chk, input bit poke);
    int   cyc;
    exp_t e;
    e.lo = lo; e.hi = hi; e.ov = ov;
    q.push_back(e);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    chk(busy == 1'b1 && ro_en == 1'b1, "start_accept", int'({busy, ro_en}), 3);
    while (!cnt_valid && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      // stray starts in SETTLE (cyc 5) and GATE (cyc 50) must be ignored
      start = poke && (cyc == 5 || cyc == 50);
    end
    start = 1'b0;
    if (lat_chk) chk(cyc == LAT, "latency", cyc, LAT);
    else         chk(cyc < 400, "valid_timeout", cyc, LAT);
  endtask

  task automatic do_ack(input bit with_start);
    cnt_ack = 1'b1;
    start   = with_start;
    @(posedge clk); #1;
    cnt_ack = 1'b0;
    start   = 1'b0;
    chk(cnt_valid == 1'b0 && busy == 1'b0, "ack_to_idle", int'({cnt_valid, busy}), 0);
    if (with_start) begin
      @(posedge clk); #1;
      chk(busy == 1'b0, "start_with_ack_ignored", int'(busy), 0);
    end
  endtask

  initial begin
    int lo4, hi4;
    bit ov4;
`ifdef RO_SAT_EN
    lo4 = 15; hi4 = 15; ov4 = 1;
`else
    lo4 = 8;  hi4 = 10; ov4 = 1;
`endif
    #1;
    chk(ro_en == 0 && busy == 0 && cnt_valid == 0 && ovf == 0, "reset_flags",
        int'({ro_en, busy, cnt_valid, ovf}), 0);
    chk(cnt_data == 0, "reset_data", int'(cnt_data), 0);
    #20;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // stuck-low ring, exact latency, stray starts ignored
    rmode = 0;
    run_meas(0, 0, 0, 1, 1);
    do_ack(0);
    // stuck-high ring
    rmode = 1;
    repeat (5) @(posedge clk);
    #1;
    run_meas(0, 0, 0, 1, 0);
    do_ack(0);
    // period 10 ring
    rmode = 2; rhalf = 5;
    run_meas(9, 11, 0, 1, 0);
    do_ack(1);
    // period 4 ring: overflow, then long hold without ack
    rhalf = 2;
    run_meas(lo4, hi4, ov4, 1, 0);
    for (int i = 1; i <= 500; i++) begin
      @(posedge clk); #1;
      if (i % 100 == 0) begin
        chk(cnt_valid == 1 && ro_en == 0 && busy == 1, "hold_flags", int'({cnt_valid, ro_en, busy}), 5);
        chk(int'(cnt_data) >= lo4 && int'(cnt_data) <= hi4 && ovf == ov4, "hold_data", int'(cnt_data), lo4);
      end
    end
    do_ack(0);
    // period 20 ring
    rhalf = 10;
    run_meas(4, 6, 0, 1, 0);
    do_ack(0);
    // async reset in the middle of GATE
    rhalf = 5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk(ro_en == 0 && busy == 0 && cnt_valid == 0 && ovf == 0, "midgate_reset_flags",
        int'({ro_en, busy, cnt_valid, ovf}), 0);
    chk(cnt_data == 0, "midgate_reset_data", int'(cnt_data), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_meas(9, 11, 0, 1, 0);
    do_ack(0);

    @(negedge clk);
    chk(q.size() == 0, "pending_results", q.size(), 0);
    chk(nres == 6, "result_count", nres, 6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
